brick_scheduler: RTL and testbench

Sequences the falling-brick game engine: a level-dependent gravity timer and debounced player move requests feed a single command channel into the game logic. One command is issued at a time over a valid/ready handshake. The block sits between the time base (which supplies the `tick` strobe) and the board-update logic.

---
 rtl/brick_pkg.sv | 45 ++++
 rtl/drop_timer.sv | 60 ++++++
 rtl/brick_scheduler.sv | 120 ++++++++++++
 tb/tb_brick_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared definitions for the falling-brick command scheduler: command codes,
// FSM state encoding, default gravity constants and the fixed-priority arbiter.
package brick_pkg;

  typedef enum logic [1:0] {
    CMD_DROP  = 2'd0,
    CMD_LEFT  = 2'd1,
    CMD_RIGHT = 2'd2,
    CMD_ROT   = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LEVEL_W     = 4;
  localparam int DEF_BASE_PERIOD = 50;
  localparam int DEF_STEP        = 4;
  localparam int DEF_MIN_PERIOD  = 5;
  localparam int DEF_SOFT_PERIOD = 3;

  // Request/flag vectors are indexed by command code, so bit n belongs to code n.
  function automatic logic [3:0] arb_grant(input logic [3:0] req);
    logic [3:0] g;
    g = '0;
    if (req[CMD_DROP])       g[CMD_DROP]  = 1'b1;
    else if (req[CMD_ROT])   g[CMD_ROT]   = 1'b1;
    else if (req[CMD_LEFT])  g[CMD_LEFT]  = 1'b1;
    else if (req[CMD_RIGHT]) g[CMD_RIGHT] = 1'b1;
    return g;
  endfunction

  function automatic cmd_e grant_code(input logic [3:0] g);
    cmd_e c;
    c = CMD_DROP;
    if (g[CMD_ROT])        c = CMD_ROT;
    else if (g[CMD_LEFT])  c = CMD_LEFT;
    else if (g[CMD_RIGHT]) c = CMD_RIGHT;
    return c;
  endfunction

endpackage

// File: rtl/drop_timer.sv
// Gravity timer: derives the level/soft-drop dependent period and counts ticks,
// emitting a one-cycle expire strobe in the cycle the period is reached.
module drop_timer
  import brick_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP        = DEF_STEP,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int SOFT_PERIOD = DEF_SOFT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               clear,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  output logic               expire
);

  localparam int PROD_W = LEVEL_W + CNT_W;

  logic [PROD_W-1:0] prod;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    cnt_inc;
  logic              hit;
  logic              advance;

  assign prod = PROD_W'(level) * PROD_W'(STEP);

  // Saturate before subtracting so the period never goes through a negative value.
  always_comb begin
    period = CNT_W'(SOFT_PERIOD);
    if (!soft_drop) begin
      if (prod >= PROD_W'(BASE_PERIOD - MIN_PERIOD))
        period = CNT_W'(MIN_PERIOD);
      else
        period = CNT_W'(PROD_W'(BASE_PERIOD) - prod);
    end
  end

  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
  assign hit     = cnt_inc >= {1'b0, period};
  assign advance = tick && !pause && !clear;
  assign expire  = advance && hit;

  // Greater-or-equal lets a shortened period expire on the next tick instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (advance)
      cnt <= hit ? '0 : cnt_inc[CNT_W-1:0];
  end

endmodule

// File: rtl/brick_scheduler.sv
// Command scheduler top: pending flags, fixed-priority arbiter and the
// IDLE/ISSUE/WAIT handshake FSM that offers one command at a time.
module brick_scheduler
  import brick_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP        = DEF_STEP,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int SOFT_PERIOD = DEF_SOFT_PERIOD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               clear,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               mv_left,
  input  logic               mv_right,
  input  logic               mv_rot,
  output logic               cmd_valid,
  output logic [1:0]         cmd,
  input  logic               cmd_ready,
  output logic               overrun
);

  state_e     state, state_nxt;
  cmd_e       cmd_q;
  logic       expire;
  logic [3:0] flags, flags_nxt;
  logic [3:0] sets;
  logic [3:0] req;
  logic [3:0] grant;

  drop_timer #(
    .CNT_W       (CNT_W),
    .LEVEL_W     (LEVEL_W),
    .BASE_PERIOD (BASE_PERIOD),
    .STEP        (STEP),
    .MIN_PERIOD  (MIN_PERIOD),
    .SOFT_PERIOD (SOFT_PERIOD)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .clear     (clear),
    .pause     (pause),
    .level     (level),
    .soft_drop (soft_drop),
    .expire    (expire)
  );

  assign sets = {mv_rot && !pause, mv_right && !pause, mv_left && !pause, expire};

  // Incoming events are arbitrated alongside stored flags so IDLE can issue without a wait cycle.
  always_comb begin
    req = '0;
    if (state == ST_IDLE && !pause && !clear)
      req = flags | sets;
  end

  assign grant = arb_grant(req);

  // An event granted straight from its pulse is consumed; one landing on a granted stored flag re-arms it.
  always_comb begin
    flags_nxt = (flags & ~grant) | (sets & (~grant | flags));
    if (pause)
      flags_nxt[3:1] = '0;
    if (clear)
      flags_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags <= '0;
    else
      flags <= flags_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (clear)
      overrun <= 1'b0;
    else if (expire && flags[CMD_DROP] && !grant[CMD_DROP])
      overrun <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cmd_q <= CMD_DROP;
    else if (|grant)
      cmd_q <= grant_code(grant);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (|grant) state_nxt = ST_ISSUE;
      ST_ISSUE: if (cmd_ready || clear) state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == ST_ISSUE);
    cmd       = cmd_q;
  end

endmodule

// File: tb/tb_brick_scheduler.sv
// Directed bench for brick_scheduler: gravity timing, arbitration order, stalls,
// soft drop, pause, reset and clear, with hand-computed expectations.
module tb_brick_scheduler;
  import brick_pkg::*;

  logic       clk = 1'b0;
  logic       reset, tick, clear, pause, soft_drop;
  logic       mv_left, mv_right, mv_rot, cmd_ready;
  logic [3:0] level;
  logic       cmd_valid, overrun;
  logic [1:0] cmd;

  int checks = 0;
  int errors = 0;
  int nvalid, first, bad;
  logic [7:0] vseq;
  logic [5:0] cseq;

  always #5 clk = ~clk;

  brick_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .clear     (clear),
    .pause     (pause),
    .level     (level),
    .soft_drop (soft_drop),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .mv_rot    (mv_rot),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .overrun   (overrun)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive strobes, take the edge, sample 1 time unit after it.
  task automatic applyStimulus(input logic t, input logic l, input logic r, input logic ro);
    tick = t; mv_left = l; mv_right = r; mv_rot = ro;
    @(posedge clk);
    #1;
    tick = 1'b0; mv_left = 1'b0; mv_right = 1'b0; mv_rot = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; clear = 1'b0; pause = 1'b0; soft_drop = 1'b0;
    mv_left = 1'b0; mv_right = 1'b0; mv_rot = 1'b0; cmd_ready = 1'b0; level = 4'd0;
    #12;
    checkOutput("rst_valid", cmd_valid, 0);
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] level 0 gravity");
    cmd_ready = 1'b1;
    nvalid = 0; first = -1; bad = 0;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = i;
        if (cmd !== CMD_DROP) bad++;
      end
    end
    checkOutput("l0_drop_count", nvalid, 1);
    checkOutput("l0_drop_tick", first, 50);
    checkOutput("l0_drop_code", bad, 0);

    $display("[TB] level 15 gravity");
    level = 4'd15;
    doClear();
    nvalid = 0; first = -1;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = i;
      end
    end
    checkOutput("l15_drop_count", nvalid, 4);
    checkOutput("l15_first_tick", first, 5);

    $display("[TB] drop/left/right ordering");
    doClear();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    vseq = '0; cseq = '0; nvalid = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      vseq[k] = cmd_valid;
      if (cmd_valid === 1'b1 && nvalid < 3) begin
        cseq[nvalid*2 +: 2] = cmd;
        nvalid++;
      end
    end
    checkOutput("order_valid_pattern", vseq, 8'b0100_1001);
    checkOutput("order_cmd_sequence", cseq, 6'b10_01_00);

    $display("[TB] stalled drop and overrun");
    doClear();
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_issue_valid", cmd_valid, 1);
    bad = 0;
    for (int j = 0; j < 200; j++) begin
      applyStimulus(j < 20, 1'b0, 1'b0, 1'b0);
      if (cmd_valid !== 1'b1 || cmd !== CMD_DROP) bad++;
    end
    checkOutput("stall_stable", bad, 0);
    checkOutput("stall_overrun", overrun, 1);
    cmd_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) nvalid++;
    end
    checkOutput("stall_extra_drops", nvalid, 1);
    checkOutput("overrun_sticky", overrun, 1);
    doClear();
    checkOutput("overrun_cleared", overrun, 0);

    $display("[TB] soft drop");
    level = 4'd0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) nvalid++;
    end
    checkOutput("soft_pre_count", nvalid, 0);
    soft_drop = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("soft_first_drop", cmd_valid, 1);
    nvalid = 0; first = -1;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = i;
      end
    end
    checkOutput("soft_drop_count", nvalid, 3);
    checkOutput("soft_first_period", first, 3);
    soft_drop = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) nvalid++;
    end
    checkOutput("soft_release_count", nvalid, 0);

    $display("[TB] pause");
    level = 4'd15;
    doClear();
    cmd_ready = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    pause = 1'b1;
    cmd_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 101; i++) begin
      applyStimulus(1'b1, (i % 10) == 5, 1'b0, (i % 10) == 0);
      if (cmd_valid === 1'b1) nvalid++;
    end
    checkOutput("pause_no_cmds", nvalid, 0);
    pause = 1'b0;
    nvalid = 0; first = -1; bad = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) begin
        nvalid++;
        if (first < 0) first = i;
        if (cmd !== CMD_DROP) bad++;
      end
    end
    checkOutput("resume_cmd_count", nvalid, 1);
    checkOutput("resume_first", first, 0);
    checkOutput("resume_is_drop", bad, 0);
    first = -1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1 && first < 0) first = i;
    end
    checkOutput("pause_cnt_frozen", first, 2);

    $display("[TB] reset and clear during issue");
    doClear();
    cmd_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_pre_valid", cmd_valid, 1);
    checkOutput("rst_pre_cmd", cmd, CMD_RIGHT);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", cmd_valid, 0);
    checkOutput("async_rst_cmd", cmd, 0);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_valid", cmd_valid, 0);
    cmd_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_pre_cmd", cmd, CMD_ROT);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    clear = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    checkOutput("clear_drops_valid", cmd_valid, 0);
    cmd_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (cmd_valid === 1'b1) nvalid++;
    end
    checkOutput("clear_no_flags", nvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
